// File: rtl/coord_scanner_if.sv
// Coordinate beat bus between the scanner and the rotator stage.
// Latency: n/a (wires only).
// Backpressure: a beat is transferred when out_valid and out_ready are both high.
//
// Signals:
//   out_valid / out_ready : beat handshake
//   Xcoord, Ycoord        : destination coordinate of the beat
//   Angle                 : rotation angle for the whole frame
//   sof / eol / eof       : first beat of frame / last beat of row / last beat of frame
interface coord_scanner_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Xcoord;
    logic [7:0] Ycoord;
    logic [7:0] Angle;
    logic       sof;
    logic       eol;
    logic       eof;

    modport master (
        output out_valid,
        output Xcoord,
        output Ycoord,
        output Angle,
        output sof,
        output eol,
        output eof,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  Xcoord,
        input  Ycoord,
        input  Angle,
        input  sof,
        input  eol,
        input  eof,
        output out_ready
    );
endinterface

// File: rtl/coord_scanner.sv
// Raster (X,Y) coordinate generator with a per-frame rotation angle that advances each frame.
// Latency: first beat is presented the cycle after start; one beat per accepted handshake.
// Backpressure: out_ready low holds the current beat (X, Y, Angle) stable until accepted.
//
// Ports:
//   ACLK, ARESETn          : clock (rising edge), asynchronous active-low reset
//   start, abort           : begin a frame from IDLE / return to IDLE (abort wins)
//   continuous             : restart automatically after each frame (after GAP_CYCLES idle cycles)
//   angle_step, angle_init : angle increment at end of frame / angle loaded on start
//   m                      : coordinate beat bus (coord_scanner_if.master)
//   busy, frame_count      : state != IDLE / completed frames (wrapping)
// Optional build macro: SCAN_SERPENTINE_EN -- odd rows run X from H_MAX down to 0.
module coord_scanner #(
    parameter int H_MAX      = 255,
    parameter int V_MAX      = 255,
    parameter int GAP_CYCLES = 4
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        start,
    input  logic        abort,
    input  logic        continuous,
    input  logic [7:0]  angle_step,
    input  logic [7:0]  angle_init,
    coord_scanner_if.master m,
    output logic        busy,
    output logic [15:0] frame_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, GAP = 2'd2} state_t;

    localparam logic [7:0] X_LAST = 8'(H_MAX);
    localparam logic [7:0] Y_LAST = 8'(V_MAX);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // Only meaningful when GAP_CYCLES > 0; GAP is unreachable otherwise.
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t        state, state_nxt;
    logic [7:0]    x, y, angle;
    logic [15:0]   fcnt;
    logic [GW-1:0] gap_cnt;

    logic xfer;
    logic row_rev;
    logic row_end;
    logic last_beat;

    assign xfer = m.out_valid & m.out_ready;

`ifdef SCAN_SERPENTINE_EN
    assign row_rev = y[0];
`else
    assign row_rev = 1'b0;
`endif

    // Row end depends on the direction the current row is being swept.
    assign row_end   = row_rev ? (x == 8'd0) : (x == X_LAST);
    assign last_beat = row_end && (y == Y_LAST);

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (xfer && last_beat) begin
                    if (!continuous) begin
                        state_nxt = IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        state_nxt = SCAN;
                    end else begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = continuous ? SCAN : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    // Output decode
    always_comb begin
        m.out_valid = (state == SCAN);
        m.sof       = m.out_valid && (x == 8'd0) && (y == 8'd0);
        m.eol       = m.out_valid && row_end;
        m.eof       = m.out_valid && last_beat;
        busy        = (state != IDLE);
    end

    assign m.Xcoord    = x;
    assign m.Ycoord    = y;
    assign m.Angle     = angle;
    assign frame_count = fcnt;

    // Coordinate, angle, frame and gap counters
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            x       <= 8'd0;
            y       <= 8'd0;
            angle   <= 8'd0;
            fcnt    <= 16'd0;
            gap_cnt <= '0;
        end else if (abort) begin
            // Abort drops the sweep but keeps the animation state, even on the eof beat.
            x       <= 8'd0;
            y       <= 8'd0;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x     <= 8'd0;
                        y     <= 8'd0;
                        angle <= angle_init;
                    end
                end
                SCAN: begin
                    gap_cnt <= '0;
                    if (xfer) begin
                        if (row_end) begin
                            if (y == Y_LAST) begin
                                x     <= 8'd0;
                                y     <= 8'd0;
                                angle <= angle + angle_step;
                                fcnt  <= fcnt + 16'd1;
                            end else begin
                                y <= y + 8'd1;
`ifdef SCAN_SERPENTINE_EN
                                // Leaving an even row starts an odd (reversed) row at the far end.
                                x <= y[0] ? 8'd0 : X_LAST;
`else
                                x <= 8'd0;
`endif
                            end
                        end else begin
                            x <= row_rev ? (x - 8'd1) : (x + 8'd1);
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coord_scanner.sv
// Self-checking bench for coord_scanner (H_MAX=3, V_MAX=1, GAP_CYCLES=4).
// Directed scenarios followed by randomized stimulus; a frame-level reference model
// predicts each cycle's outputs into a queue that an independent monitor drains.
module tb_coord_scanner;
    localparam int H   = 3;
    localparam int V   = 1;
    localparam int GAP = 4;
    localparam int W   = H + 1;
    localparam int N   = W * (V + 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        continuous = 1'b0;
    logic [7:0]  angle_step = 8'd0;
    logic [7:0]  angle_init = 8'd0;
    logic        busy;
    logic [15:0] frame_count;

    coord_scanner_if bus();

    coord_scanner #(.H_MAX(H), .V_MAX(V), .GAP_CYCLES(GAP)) dut (
        .ACLK        (clk),
        .ARESETn     (rst_n),
        .start       (start),
        .abort       (abort),
        .continuous  (continuous),
        .angle_step  (angle_step),
        .angle_init  (angle_init),
        .m           (bus),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int x, y, ang, fc;
        bit sof, eol, eof, busy;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: frame-level view (active sweep, beat index, gap countdown).
    bit m_active;
    int m_gap;
    int m_k;
    int m_ang;
    int m_fc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_gap = 0; m_k = 0; m_ang = 0; m_fc = 0;
    endtask

    // Predict the outputs visible this cycle, then advance by one clock using current inputs.
    task automatic model_step();
        exp_t e;
        int c, r;
        c = m_k % W;
        r = m_k / W;
        e.valid = m_active;
        e.x = c;
`ifdef SCAN_SERPENTINE_EN
        if (r % 2 == 1) e.x = H - c;
`endif
        e.y    = r;
        e.sof  = m_active && (m_k == 0);
        e.eol  = m_active && (c == H);
        e.eof  = m_active && (m_k == N - 1);
        e.busy = m_active || (m_gap > 0);
        e.ang  = m_ang;
        e.fc   = m_fc;
        expq.push_back(e);

        if (abort) begin
            m_active = 0; m_gap = 0; m_k = 0;
        end else if (!m_active && m_gap == 0) begin
            if (start) begin
                m_active = 1; m_k = 0; m_ang = angle_init;
            end
        end else if (m_active) begin
            if (bus.out_ready) begin
                if (m_k == N - 1) begin
                    m_ang = (m_ang + angle_step) % 256;
                    m_fc  = (m_fc + 1) % 65536;
                    m_k   = 0;
                    if (!continuous) m_active = 0;
                    else if (GAP > 0) begin m_active = 0; m_gap = GAP; end
                end else begin
                    m_k++;
                end
            end
        end else begin
            m_gap--;
            if (m_gap == 0 && continuous) begin
                m_active = 1; m_k = 0;
            end
        end
    endtask

    task automatic cycle(input bit st, input bit ab, input bit co,
                         input logic [7:0] stp, input logic [7:0] ini, input bit rdy);
        @(negedge clk);
        start = st; abort = ab; continuous = co;
        angle_step = stp; angle_init = ini; bus.out_ready = rdy;
        model_step();
    endtask

    task automatic async_reset_check();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_x", bus.Xcoord, 0);
        chk("rst_y", bus.Ycoord, 0);
        chk("rst_angle", bus.Angle, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_busy", busy, 0);
        expq.delete();
        start = 0; abort = 0; bus.out_ready = 0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: drains one prediction per cycle, well away from the clock edges.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("valid", bus.out_valid, e.valid);
                chk("busy", busy, e.busy);
                chk("angle", bus.Angle, e.ang);
                chk("frame_count", frame_count, e.fc);
                chk("sof", bus.sof, e.sof);
                chk("eol", bus.eol, e.eol);
                chk("eof", bus.eof, e.eof);
                if (e.valid) begin
                    chk("x", bus.Xcoord, e.x);
                    chk("y", bus.Ycoord, e.y);
                end
            end
        end
    end

    initial begin
        int  n;
        int  fc_before;
        bit  cont_r;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("por_valid", bus.out_valid, 0);
        chk("por_fc", frame_count, 0);
        rst_n = 1'b1;

        // Single frame with a 3-cycle stall on beat (2,0).
        cycle(1, 0, 0, 8'h05, 8'h10, 1);
        for (int i = 0; i < 14; i++)
            cycle(0, 0, 0, 8'h05, 8'h10, !(i >= 2 && i < 5));
        chk("single_angle", bus.Angle, 8'h15);
        chk("single_fc", frame_count, 1);
        chk("single_idle", busy, 0);

        // Continuous mode with angle wrap and a 4-cycle inter-frame gap.
        cycle(1, 0, 1, 8'h03, 8'hFE, 1);
        for (int i = 0; i < N; i++)
            cycle(0, 0, 1, 8'h03, 8'hFE, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 1, 8'h03, 8'hFE, 1);
            if (bus.out_valid) break;
            n++;
        end
        chk("gap_len", n, GAP);
        chk("frame2_sof", bus.sof, 1);
        chk("frame2_angle", bus.Angle, 8'h01);
        for (int i = 0; i < N + 3; i++)
            cycle(0, 0, 0, 8'h03, 8'hFE, 1);
        chk("cont_fc", frame_count, 3);
        chk("cont_idle", busy, 0);

        // Abort coinciding with the eof transfer.
        fc_before = frame_count;
        cycle(1, 0, 0, 8'h07, 8'h20, 1);
        for (int i = 0; i < N - 1; i++)
            cycle(0, 0, 0, 8'h07, 8'h20, 1);
        cycle(0, 1, 0, 8'h07, 8'h20, 1);
        chk("abort_on_eof_beat", bus.eof, 1);
        cycle(0, 0, 0, 8'h07, 8'h20, 1);
        chk("abort_idle", busy, 0);
        chk("abort_angle", bus.Angle, 8'h20);
        chk("abort_fc", frame_count, fc_before);

        // Asynchronous reset in the middle of a sweep.
        cycle(1, 0, 0, 8'h01, 8'h33, 1);
        for (int i = 0; i < 5; i++)
            cycle(0, 0, 0, 8'h01, 8'h33, 1);
        async_reset_check();

        // Randomized traffic.
        cont_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) cont_r = !cont_r;
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0, cont_r,
                  8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
        end
        cycle(0, 0, 0, 8'h00, 8'h00, 1);
        @(negedge clk);
        #4;
        chk("scoreboard_drained", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/coord_scanner.md
Name: coord_scanner

Overview:
- Upstream coordinate source for the rotator stage.
- Sweeps a raster of (X, Y) destination coordinates, one coordinate per accepted beat, and presents them with a per-frame rotation angle.
- Angle is held constant for a whole frame, then advances by a programmable step at each frame boundary, so consecutive frames animate the rotation.
- Uses a valid/ready handshake so downstream stages can stall the sweep.

Parameters:
- H_MAX, 255: last X value of a row; range 0..255.
- V_MAX, 255: last Y value of a frame; range 0..255.
- GAP_CYCLES, 4: idle cycles between frames in continuous mode; 0 means back-to-back frames.

Ports:
- ACLK  input  1  system clock, rising edge.
- ARESETn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a frame when idle.
- abort  input  1  synchronous; terminates the current sweep.
- continuous  input  1  1 = restart automatically after each frame.
- angle_step  input  8  angle increment applied at end of frame; sampled at the last beat.
- angle_init  input  8  angle loaded on start from IDLE.
- out_ready  input  1  downstream accepts a beat.
- out_valid  output  1  Xcoord/Ycoord/Angle are valid.
- Xcoord  output  8  current X.
- Ycoord  output  8  current Y.
- Angle  output  8  frame angle.
- sof  output  1  first beat of frame (X=0, Y=0) while out_valid.
- eol  output  1  last beat of row while out_valid.
- eof  output  1  last beat of frame while out_valid.
- busy  output  1  state is not IDLE.
- frame_count  output  16  completed frames, wraps at 65535->0.

Behaviour:
- Reset (ARESETn low, asynchronous):
  - state IDLE.
  - out_valid, Xcoord, Ycoord, Angle, busy and frame_count all 0.
  - sof, eol and eof are 0.
- States: IDLE, SCAN, GAP.
- IDLE:
  - out_valid=0.
  - start=1: next cycle state=SCAN, X=0, Y=0, Angle=angle_init, out_valid=1.
- SCAN:
  - Transfer occurs when out_valid & out_ready.
  - No transfer: X, Y and Angle hold stable.
  - Transfer, X<H_MAX: X+1.
  - Transfer, X=H_MAX and Y<V_MAX: X=0, Y+1.
  - Transfer, X=H_MAX and Y=V_MAX (eof beat):
    - Angle <= Angle+angle_step, mod 256.
    - frame_count+1.
    - X=0, Y=0.
    - continuous=0 -> IDLE, out_valid=0.
    - continuous=1, GAP_CYCLES=0 -> stay in SCAN, out_valid stays 1, so the next frame's sof beat follows in the next cycle.
    - continuous=1, GAP_CYCLES>0 -> GAP, out_valid=0.
- GAP:
  - Counts GAP_CYCLES cycles.
  - Then SCAN with out_valid=1, X=0, Y=0; Angle already advanced.
  - continuous sampled at the last GAP cycle; if 0, go to IDLE instead.
- start while in SCAN or GAP is ignored.
- sof, eol and eof are combinational decodes of the registered X/Y/state, gated by out_valid.
- abort=1 in any state:
  - Next cycle IDLE, out_valid=0, X=0, Y=0.
  - Angle and frame_count retained.
  - abort has priority over start and over the eof beat: if abort coincides with the eof transfer, the beat counts as accepted, but Angle and frame_count are NOT updated.
- H_MAX=0 or V_MAX=0: single-column or single-row frames; eol and eof decode unchanged.
- busy = (state != IDLE).

Optional Feature:
- Macro: SCAN_SERPENTINE_EN.
- Defined (serpentine scan):
  - Odd rows (Y[0]=1) run X from H_MAX down to 0.
  - eol on an odd row is asserted at X=0.
  - Row advance on an odd row sets X=0 for the next even row; row advance on an even row sets X=H_MAX for the next odd row.
  - eof is the last beat of row V_MAX in its scan direction.
- Undefined: every row runs 0..H_MAX (raster order).

Test Plan:
- Reset then idle:
  - Stimulus: ARESETn low mid-SCAN at X=5, Y=2.
  - Response: out_valid, Xcoord, Ycoord, Angle and frame_count are 0 immediately, without a clock edge.
- Single frame:
  - Setup: H_MAX=3, V_MAX=1, angle_init=8'h10, angle_step=8'h05, continuous=0, out_ready=1.
  - Stimulus: start.
  - Response: 8 beats (0,0)..(3,1); eol at X=3; eof on beat 8; then IDLE with Angle=8'h15 and frame_count=1.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles at (2,0).
  - Response: (2,0) held stable; no beat skipped or duplicated.
- Continuous with wrap:
  - Setup: angle_init=8'hFE, angle_step=8'h03, GAP_CYCLES=4.
  - Response: second frame Angle=8'h01; exactly 4 cycles with out_valid=0 between eof and sof.
- Abort on eof:
  - Stimulus: abort asserted together with the eof transfer.
  - Response: next cycle IDLE; Angle and frame_count unchanged.
- Serpentine (SCAN_SERPENTINE_EN defined):
  - Setup: H_MAX=2, V_MAX=1.
  - Response: order (0,0)(1,0)(2,0)(2,1)(1,1)(0,1); eof at (0,1).
